// File: rtl/cpu_mem_io_if.sv
// Core-side bus plus TX/RX byte streams for the cpu memory/IO target.
// The master modport belongs to whoever drives the core and stream inputs.
interface cpu_mem_io_if;
    logic [31:0] address;
    logic [31:0] datai;
    logic        rw;
    logic [31:0] data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output address, datai, rw, out_ready, in_data, in_valid,
        input  data, out_data, out_valid, in_ready
    );

    modport slave (
        input  address, datai, rw, out_ready, in_data, in_valid,
        output data, out_data, out_valid, in_ready
    );
endinterface

// File: rtl/cpu_mem_io.sv
// Word RAM plus memory-mapped TX/RX byte FIFOs serving the cpu core every clock.
// Reads are combinational and side-effect free; all state changes on posedge.
module cpu_mem_io #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned AW        = 10,
    parameter int unsigned FIFO_D    = 8,
    parameter logic [31:0] IO_BASE   = 32'hFFFF_FF00,
    parameter string       INIT_FILE = ""
) (
    input logic          clock,
    input logic          reset,
    cpu_mem_io_if.slave  bus
);
    localparam int unsigned FW = $clog2(FIFO_D);
    localparam int unsigned PW = FW + 1;
    localparam logic [PW-1:0] FullXor = PW'(FIFO_D);

    logic [31:0] mem [DEPTH];
    logic [7:0]  tx_mem [FIFO_D];
    logic [7:0]  rx_mem [FIFO_D];

    logic [PW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic          tx_ovf_q, rx_unf_q;
    logic [7:0]    tx_last_q;

    logic in_ram, sel_tx, sel_rx, sel_ctl, wr;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push_req, tx_push, tx_pop, ovf_set;
    logic rx_pop_req, rx_pop, rx_push, unf_set, flag_clr;
    logic [7:0] tx_head, rx_head;

    always_comb begin
        in_ram   = (bus.address[31:AW] == '0);
        sel_tx   = (bus.address == IO_BASE);
        sel_rx   = (bus.address == IO_BASE + 32'd1);
        sel_ctl  = (bus.address == IO_BASE + 32'd2);
        wr       = !bus.rw;

        tx_empty = (tx_wr_q == tx_rd_q);
        tx_full  = ((tx_wr_q ^ tx_rd_q) == FullXor);
        rx_empty = (rx_wr_q == rx_rd_q);
        rx_full  = ((rx_wr_q ^ rx_rd_q) == FullXor);

        tx_head  = tx_empty ? 8'h0 : tx_mem[tx_rd_q[FW-1:0]];
        rx_head  = rx_empty ? 8'h0 : rx_mem[rx_rd_q[FW-1:0]];

        tx_pop      = !tx_empty && bus.out_ready;
        tx_push_req = wr && sel_tx;
        tx_push     = tx_push_req && (!tx_full || tx_pop);
        ovf_set     = tx_push_req && tx_full && !tx_pop;

        rx_pop_req  = wr && sel_ctl && bus.datai[0];
        rx_pop      = rx_pop_req && !rx_empty;
        unf_set     = rx_pop_req && rx_empty;
        flag_clr    = wr && sel_ctl && bus.datai[1];
    end

    // A CPU pop frees a slot in the same cycle, so a full RX still accepts then.
    assign bus.in_ready  = !rx_full || rx_pop_req;
    assign rx_push       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = !tx_empty;
    assign bus.out_data  = tx_head;

    always_comb begin
        bus.data = 32'h0;
        if (in_ram) begin
            bus.data = mem[bus.address[AW-1:0]];
        end else if (sel_tx) begin
            bus.data = {24'h0, tx_last_q};
        end else if (sel_rx) begin
            bus.data = {23'h0, !rx_empty, rx_head};
        end else if (sel_ctl) begin
            bus.data = {26'h0, tx_ovf_q, rx_unf_q, tx_full, tx_empty, rx_full, rx_empty};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            tx_ovf_q  <= 1'b0;
            rx_unf_q  <= 1'b0;
            tx_last_q <= 8'h0;
        end else begin
            if (tx_push) begin
                tx_wr_q   <= tx_wr_q + 1'b1;
                tx_last_q <= bus.datai[7:0];
            end
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            // A new error in the same cycle as a clear wins.
            tx_ovf_q <= (tx_ovf_q && !flag_clr) || ovf_set;
            rx_unf_q <= (rx_unf_q && !flag_clr) || unf_set;
        end
    end

    always_ff @(posedge clock) begin
        if (wr && in_ram) mem[bus.address[AW-1:0]] <= bus.datai;
        if (tx_push)      tx_mem[tx_wr_q[FW-1:0]] <= bus.datai[7:0];
        if (rx_push)      rx_mem[rx_wr_q[FW-1:0]] <= bus.in_data;
    end
endmodule

// File: tb/tb_cpu_mem_io.sv
// Directed bench for cpu_mem_io: a vector table for RAM/TX/RX basics plus
// hand-written sequences for overflow, underflow, async reset and unmapped accesses.
module tb_cpu_mem_io;
    localparam logic [31:0] IO = 32'hFFFF_FF00;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    cpu_mem_io_if bus ();

    cpu_mem_io #(
        .DEPTH     (1024),
        .AW        (10),
        .FIFO_D    (8),
        .IO_BASE   (IO),
        .INIT_FILE ("")
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ordy;
        logic        ival;
        logic [7:0]  idata;
        logic        chk;
        logic [31:0] rdata;
        logic        ovalid;
        logic [7:0]  odata;
        logic        irdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ordy, input logic ival, input logic [7:0] idata,
                       input logic chk, input logic [31:0] rdata, input logic ovalid,
                       input logic [7:0] odata, input logic irdy);
        vec_t v;
        v.rw = rw; v.addr = addr; v.wdata = wdata; v.ordy = ordy; v.ival = ival;
        v.idata = idata; v.chk = chk; v.rdata = rdata; v.ovalid = ovalid;
        v.odata = odata; v.irdy = irdy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [31:0] a, input logic [31:0] d);
        bus.rw      = rw;
        bus.address = a;
        bus.datai   = d;
    endtask

    task automatic idle();
        drive(1'b1, IO + 32'd2, 32'h0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, a, 32'h0);
        #1;
        check(name, bus.data, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle();
        bus.address = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        // rw addr wdata ordy ival idata | chk rdata ovalid odata irdy
        add(1, IO+2, 0, 0, 0, 0, 1, 32'h5, 0, 8'h0, 1);
        add(0, 6, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 8'h0, 1);
        add(0, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 8'h0, 1);
        add(1, 5, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 8'h0, 1);
        add(1, 6, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 8'h0, 1);
        add(0, IO, 32'h41, 0, 0, 0, 1, 32'h0, 0, 8'h0, 1);
        add(0, IO, 32'h42, 0, 0, 0, 1, 32'h41, 1, 8'h41, 1);
        add(0, IO, 32'h43, 0, 0, 0, 1, 32'h42, 1, 8'h41, 1);
        add(1, IO, 0, 1, 0, 0, 1, 32'h43, 1, 8'h41, 1);
        add(1, IO, 0, 1, 0, 0, 1, 32'h43, 1, 8'h42, 1);
        add(1, IO, 0, 1, 0, 0, 1, 32'h43, 1, 8'h43, 1);
        add(1, IO, 0, 0, 0, 0, 1, 32'h43, 0, 8'h0, 1);
        add(1, IO+1, 0, 0, 1, 8'h10, 1, 32'h0, 0, 8'h0, 1);
        add(1, IO+1, 0, 0, 0, 0, 1, 32'h110, 0, 8'h0, 1);
        add(1, IO+2, 0, 0, 0, 0, 1, 32'h4, 0, 8'h0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            bus.out_ready = vecs[i].ordy;
            bus.in_valid  = vecs[i].ival;
            bus.in_data   = vecs[i].idata;
            #1;
            if (vecs[i].chk) check($sformatf("vec%0d data", i), bus.data, vecs[i].rdata);
            check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ovalid));
            check($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].odata));
            check($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].irdy));
            tick();
        end

        // TX overflow, push-at-full with drain, flag clear
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, IO, 32'hA0 + 32'(i));
            tick();
        end
        read_check("t3 status full ovf", IO + 32'd2, 32'h29);
        check("t3 head", 32'(bus.out_data), 32'hA0);
        drive(1'b0, IO, 32'hB0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        read_check("t3 status after push+drain", IO + 32'd2, 32'h29);
        read_check("t3 last tx byte", IO, 32'hB0);
        drive(1'b0, IO + 32'd2, 32'h2);
        tick();
        read_check("t3 status after clear", IO + 32'd2, 32'h09);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_b;
            exp_b = (i < 7) ? 8'(8'hA1 + i) : 8'hB0;
            #1;
            check($sformatf("t3 drain%0d valid", i), 32'(bus.out_valid), 32'h1);
            check($sformatf("t3 drain%0d byte", i), 32'(bus.out_data), 32'(exp_b));
            tick();
        end
        bus.out_ready = 1'b0;
        read_check("t3 status drained", IO + 32'd2, 32'h05);
        check("t3 out_valid drained", 32'(bus.out_valid), 32'h0);

        // RX fill, pop with simultaneous push at full, underflow
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, IO + 32'd1, 32'h0);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h10 + 8'(i);
            #1;
            check($sformatf("t4 in_ready%0d", i), 32'(bus.in_ready), 32'h1);
            tick();
        end
        bus.in_valid = 1'b0;
        read_check("t4 rx head full", IO + 32'd1, 32'h110);
        check("t4 in_ready full", 32'(bus.in_ready), 32'h0);
        read_check("t4 status full", IO + 32'd2, 32'h06);
        drive(1'b0, IO + 32'd2, 32'h1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h18;
        #1;
        check("t4 in_ready on pop", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        read_check("t4 head after pop+push", IO + 32'd1, 32'h111);
        read_check("t4 still full", IO + 32'd2, 32'h06);
        for (int i = 0; i < 9; i++) begin
            read_check($sformatf("t4 pop%0d head", i), IO + 32'd1,
                       (i < 8) ? 32'h111 + 32'(i) : 32'h0);
            drive(1'b0, IO + 32'd2, 32'h1);
            tick();
        end
        read_check("t4 status underflow", IO + 32'd2, 32'h15);
        drive(1'b0, IO + 32'd2, 32'h3);
        tick();
        read_check("t4 clear vs new unf", IO + 32'd2, 32'h15);
        drive(1'b0, IO + 32'd2, 32'h2);
        tick();
        read_check("t4 unf cleared", IO + 32'd2, 32'h05);

        // Async reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, IO, 32'h1 + 32'(i));
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, IO + 32'd1, 32'h0);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h60 + 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        drive(1'b0, 32'd5, 32'hCAFE_F00D);
        tick();
        drive(1'b1, IO + 32'd2, 32'h0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("t5 out_valid before reset", 32'(bus.out_valid), 32'h1);
        reset = 1'b1;
        #1;
        check("t5 out_valid in reset", 32'(bus.out_valid), 32'h0);
        check("t5 in_ready in reset", 32'(bus.in_ready), 32'h1);
        check("t5 out_data in reset", 32'(bus.out_data), 32'h0);
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        read_check("t5 status after reset", IO + 32'd2, 32'h05);
        read_check("t5 ram kept", 32'd5, 32'hCAFE_F00D);
        read_check("t5 last tx cleared", IO, 32'h0);

        // Unmapped writes and read-only hold
        do_reset();
        drive(1'b0, 32'd0, 32'h1111_1111);
        tick();
        drive(1'b0, 32'd1024, 32'h2222_2222);
        tick();
        drive(1'b0, IO + 32'd3, 32'h41);
        tick();
        read_check("t6 ram0 intact", 32'd0, 32'h1111_1111);
        read_check("t6 depth reads 0", 32'd1024, 32'h0);
        read_check("t6 io+3 reads 0", IO + 32'd3, 32'h0);
        read_check("t6 status", IO + 32'd2, 32'h05);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, IO + 32'd1, 32'h0);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h20 + 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_check($sformatf("t6 hold%0d", i), IO + 32'd1, 32'h120);
            tick();
        end
        drive(1'b0, IO + 32'd2, 32'h1);
        tick();
        read_check("t6 second entry", IO + 32'd1, 32'h121);
        drive(1'b0, IO + 32'd2, 32'h1);
        tick();
        read_check("t6 rx drained", IO + 32'd2, 32'h05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
